fc_apu_req_queue: RTL and testbench

Request queue and outstanding-operation tracker between the FC core's APU master port and the FPU wrapper. It buffers up to DEPTH APU requests (operands, opcode, flags) and issues them in order to the FPU over a req/gnt handshake. It caps in-flight FPU operations at MAX_OUTSTANDING and registers the FPU response before returning it to the core. The FPU response channel has no backpressure, so this block never stalls responses; it throttles only issue.

---
 rtl/fc_apu_req_queue.sv | 166 ++++++++++++++++
 tb/tb_fc_apu_req_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_apu_req_queue.sv
// APU request queue between the FC core and the FPU wrapper.
// Buffers up to DEPTH requests and issues them in order over req/gnt. It
// caps in-flight FPU operations at MAX_OUTSTANDING and registers each FPU
// response for one cycle before returning it to the core.
// Handshakes: a transfer happens in any cycle where valid (apu_req_i /
// fpu_req_o) and grant (apu_gnt_o / fpu_gnt_i) are both high. Once raised,
// fpu_req_o and its payload hold until granted, unless clear_i drops the queue.
// The response channel has no grant and is never stalled.
module fc_apu_req_queue #(
  parameter int DEPTH           = 2,
  parameter int NARGS           = 3,
  parameter int WOP             = 6,
  parameter int NDSFLAGS        = 15,
  parameter int NUSFLAGS        = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     apu_req_i,
  output logic                     apu_gnt_o,
  input  logic [NARGS*32-1:0]      apu_operands_i,
  input  logic [WOP-1:0]           apu_op_i,
  input  logic [NDSFLAGS-1:0]      apu_flags_i,
  output logic                     fpu_req_o,
  input  logic                     fpu_gnt_i,
  output logic [NARGS*32-1:0]      fpu_operands_o,
  output logic [WOP-1:0]           fpu_op_o,
  output logic [NDSFLAGS-1:0]      fpu_flags_o,
  input  logic                     fpu_rvalid_i,
  input  logic [31:0]              fpu_rdata_i,
  input  logic [NUSFLAGS-1:0]      fpu_rflags_i,
  output logic                     apu_rvalid_o,
  output logic [31:0]              apu_rdata_o,
  output logic [NUSFLAGS-1:0]      apu_rflags_o,
  output logic                     busy_o,
  output logic                     rsp_err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] dbg_outstanding_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int AW = NARGS * 32;

  logic [AW-1:0]       opnd_q  [DEPTH];
  logic [AW-1:0]       opnd_d  [DEPTH];
  logic [WOP-1:0]      op_q    [DEPTH];
  logic [WOP-1:0]      op_d    [DEPTH];
  logic [NDSFLAGS-1:0] flags_q [DEPTH];
  logic [NDSFLAGS-1:0] flags_d [DEPTH];

  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [NUSFLAGS-1:0] rflags_q, rflags_d;
  logic                rsp_err_q, rsp_err_d;

  logic full, empty, push, issue;

  // Handshake qualifiers and head-of-queue outputs
  always_comb begin
    full           = (count_q == CW'(DEPTH));
    empty          = (count_q == '0);
    apu_gnt_o      = !full && !clear_i && !rst_i;
    fpu_req_o      = !empty && (outst_q < OW'(MAX_OUTSTANDING)) && !clear_i;
    push           = apu_req_i && apu_gnt_o;
    issue          = fpu_req_o && fpu_gnt_i;
    fpu_operands_o = opnd_q[rd_ptr_q];
    fpu_op_o       = op_q[rd_ptr_q];
    fpu_flags_o    = flags_q[rd_ptr_q];
    apu_rvalid_o   = rvalid_q;
    apu_rdata_o    = rdata_q;
    apu_rflags_o   = rflags_q;
    rsp_err_o      = rsp_err_q;
    busy_o         = !empty || (outst_q != '0) || rvalid_q;
    dbg_outstanding_o = outst_q;
  end

  // Next state: queue storage, pointers, occupancy, outstanding, response
  always_comb begin
    opnd_d   = opnd_q;
    op_d     = op_q;
    flags_d  = flags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    outst_d  = outst_q;
    rsp_err_d = rsp_err_q;
    rvalid_d = fpu_rvalid_i;
    rdata_d  = rdata_q;
    rflags_d = rflags_q;

    if (push) begin
      opnd_d[wr_ptr_q]  = apu_operands_i;
      op_d[wr_ptr_q]    = apu_op_i;
      flags_d[wr_ptr_q] = apu_flags_i;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (issue) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push && !issue) begin
      count_d = count_q + CW'(1);
    end else if (!push && issue) begin
      count_d = count_q - CW'(1);
    end
    // Dropping the queue leaves in-flight operations to complete normally
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // A return with nothing outstanding is a protocol error; hold at 0
    if (issue && !fpu_rvalid_i) begin
      outst_d = outst_q + OW'(1);
    end else if (!issue && fpu_rvalid_i) begin
      if (outst_q == '0) begin
        rsp_err_d = 1'b1;
      end else begin
        outst_d = outst_q - OW'(1);
      end
    end

    if (fpu_rvalid_i) begin
      rdata_d  = fpu_rdata_i;
      rflags_d = fpu_rflags_i;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        opnd_q[i]  <= '0;
        op_q[i]    <= '0;
        flags_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rflags_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      flags_q   <= flags_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rflags_q  <= rflags_d;
      rsp_err_q <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_fc_apu_req_queue.sv
// Directed bench for fc_apu_req_queue (DEPTH=2, MAX_OUTSTANDING=4).
module tb_fc_apu_req_queue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        apu_req_i = 1'b0;
  logic        apu_gnt_o;
  logic [95:0] apu_operands_i = '0;
  logic [5:0]  apu_op_i = '0;
  logic [14:0] apu_flags_i = '0;
  logic        fpu_req_o;
  logic        fpu_gnt_i = 1'b0;
  logic [95:0] fpu_operands_o;
  logic [5:0]  fpu_op_o;
  logic [14:0] fpu_flags_o;
  logic        fpu_rvalid_i = 1'b0;
  logic [31:0] fpu_rdata_i = '0;
  logic [4:0]  fpu_rflags_i = '0;
  logic        apu_rvalid_o;
  logic [31:0] apu_rdata_o;
  logic [4:0]  apu_rflags_o;
  logic        busy_o;
  logic        rsp_err_o;
  logic [2:0]  dbg_outstanding_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [36:0] exp_q[$];

  fc_apu_req_queue dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
    .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
    .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
    .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
    .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
    .apu_rvalid_o(apu_rvalid_o), .apu_rdata_o(apu_rdata_o), .apu_rflags_o(apu_rflags_o),
    .busy_o(busy_o), .rsp_err_o(rsp_err_o), .dbg_outstanding_o(dbg_outstanding_o)
  );

  // Clock and reset
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Driver tasks
  task automatic drive_push(input logic [95:0] ops, input logic [5:0] op, input logic [14:0] fl);
    apu_req_i      = 1'b1;
    apu_operands_i = ops;
    apu_op_i       = op;
    apu_flags_i    = fl;
  endtask

  task automatic send_rsp(input logic [31:0] data, input logic [4:0] fl);
    fpu_rvalid_i = 1'b1;
    fpu_rdata_i  = data;
    fpu_rflags_i = fl;
    exp_q.push_back({fl, data});
  endtask

  // Scoreboard: every returned result must match the oldest driven response
  always @(negedge clk_i) begin
    if (!rst_i && apu_rvalid_o) begin
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_rvalid", 1, 0);
      end else begin
        check_val("sb_rsp", {apu_rflags_o, apu_rdata_o}, exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset values
    #3;
    check_val("rst_gnt", apu_gnt_o, 0);
    check_val("rst_fpu_req", fpu_req_o, 0);
    check_val("rst_fpu_ops", fpu_operands_o, 0);
    check_val("rst_rvalid", apu_rvalid_o, 0);
    check_val("rst_rdata", apu_rdata_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_err", rsp_err_o, 0);
    check_val("rst_outst", dbg_outstanding_o, 0);
    step(); step();
    rst_i = 1'b0;
    #1 check_val("gnt_after_rst", apu_gnt_o, 1);

    // Single request, issue latency of one cycle
    fpu_gnt_i = 1'b1;
    drive_push({32'h0, 32'h40000000, 32'h3F800000}, 6'h00, 15'h0123);
    #1 check_val("t1_gnt", apu_gnt_o, 1);
    check_val("t1_no_bypass", fpu_req_o, 0);
    step();
    apu_req_i = 1'b0;
    #1 check_val("t1_req", fpu_req_o, 1);
    check_val("t1_ops", fpu_operands_o, {32'h0, 32'h40000000, 32'h3F800000});
    check_val("t1_op", fpu_op_o, 6'h00);
    check_val("t1_flags", fpu_flags_o, 15'h0123);
    step();
    #1 check_val("t1_req_done", fpu_req_o, 0);
    check_val("t1_outst", dbg_outstanding_o, 1);
    check_val("t1_busy", busy_o, 1);
    send_rsp(32'h40400000, 5'h01);
    #1 check_val("t4_rvalid_n", apu_rvalid_o, 0);
    step();
    fpu_rvalid_i = 1'b0;
    #1 check_val("t4_rvalid_n1", apu_rvalid_o, 1);
    check_val("t4_rdata", apu_rdata_o, 32'h40400000);
    check_val("t4_rflags", apu_rflags_o, 5'h01);
    check_val("t4_outst", dbg_outstanding_o, 0);
    step();
    #1 check_val("t4_rvalid_n2", apu_rvalid_o, 0);
    check_val("t4_rdata_hold", apu_rdata_o, 32'h40400000);
    check_val("t4_busy_idle", busy_o, 0);

    // Fill with FPU stalled, then drain in order
    fpu_gnt_i = 1'b0;
    drive_push({3{32'hA}}, 6'h11, 15'h0AAA);
    #1 check_val("t2_gnt0", apu_gnt_o, 1);
    step();
    drive_push({3{32'hB}}, 6'h22, 15'h0BBB);
    #1 check_val("t2_gnt1", apu_gnt_o, 1);
    check_val("t2_head_a", fpu_operands_o, {3{32'hA}});
    step();
    apu_req_i = 1'b0;
    #1 check_val("t2_full_gnt", apu_gnt_o, 0);
    for (int i = 0; i < 10; i++) begin
      check_val("t2_stall_req", fpu_req_o, 1);
      check_val("t2_stall_ops", fpu_operands_o, {3{32'hA}});
      check_val("t2_stall_op", fpu_op_o, 6'h11);
      step();
      #1;
    end
    fpu_gnt_i = 1'b1;
    #1 check_val("t2_flags_a", fpu_flags_o, 15'h0AAA);
    step();
    #1 check_val("t2_op_b", fpu_op_o, 6'h22);
    check_val("t2_flags_b", fpu_flags_o, 15'h0BBB);
    check_val("t2_gnt_back", apu_gnt_o, 1);
    check_val("t2_req_b", fpu_req_o, 1);
    step();
    #1 check_val("t2_drained", fpu_req_o, 0);
    check_val("t2_outst", dbg_outstanding_o, 2);
    fpu_gnt_i = 1'b0;
    send_rsp(32'h11, 5'h02);
    step();
    send_rsp(32'h22, 5'h03);
    #1 check_val("b2b_rvalid0", apu_rvalid_o, 1);
    step();
    fpu_rvalid_i = 1'b0;
    #1 check_val("b2b_rvalid1", apu_rvalid_o, 1);
    check_val("b2b_outst", dbg_outstanding_o, 0);
    step();

    // Outstanding cap at 4
    fpu_gnt_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_push({3{32'(k)}}, 6'(k + 1), 15'(k));
      #1 check_val("t3_gnt_stream", apu_gnt_o, 1);
      step();
    end
    apu_req_i = 1'b0;
    #1 check_val("t3_cap_req", fpu_req_o, 0);
    check_val("t3_cap_outst", dbg_outstanding_o, 4);
    check_val("t3_head5", fpu_op_o, 6'h05);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 check_val("t3_cap_hold", fpu_req_o, 0);
    end
    send_rsp(32'h33, 5'h00);
    #1 check_val("t3_cap_same", fpu_req_o, 0);
    step();
    fpu_rvalid_i = 1'b0;
    #1 check_val("t3_fifth_req", fpu_req_o, 1);
    check_val("t3_fifth_op", fpu_op_o, 6'h05);
    check_val("t3_outst3", dbg_outstanding_o, 3);
    step();
    #1 check_val("t3_fifth_gone", fpu_req_o, 0);
    check_val("t3_outst4", dbg_outstanding_o, 4);

    // Issue and return in the same cycle
    drive_push({3{32'h2A}}, 6'h2A, 15'h002A);
    send_rsp(32'h44, 5'h04);
    step();
    apu_req_i = 1'b0;
    send_rsp(32'h55, 5'h05);
    #1 check_val("t4_sim_req", fpu_req_o, 1);
    check_val("t4_sim_pre", dbg_outstanding_o, 3);
    step();
    fpu_rvalid_i = 1'b0;
    #1 check_val("t4_sim_outst", dbg_outstanding_o, 3);
    check_val("t4_sim_empty", fpu_req_o, 0);
    for (int i = 0; i < 3; i++) begin
      send_rsp(32'h60 + 32'(i), 5'(i));
      step();
    end
    fpu_rvalid_i = 1'b0;
    #1 check_val("t4_drain_outst", dbg_outstanding_o, 0);
    step();

    // Clear with two queued and one in flight
    fpu_gnt_i = 1'b0;
    drive_push({3{32'hC1}}, 6'h31, 15'h0031);
    step();
    fpu_gnt_i = 1'b1;
    drive_push({3{32'hC2}}, 6'h32, 15'h0032);
    step();
    fpu_gnt_i = 1'b0;
    drive_push({3{32'hC3}}, 6'h33, 15'h0033);
    step();
    apu_req_i = 1'b0;
    #1 check_val("t5_req_before", fpu_req_o, 1);
    check_val("t5_full", apu_gnt_o, 0);
    check_val("t5_outst", dbg_outstanding_o, 1);
    check_val("t5_head", fpu_op_o, 6'h32);
    clear_i = 1'b1;
    #1 check_val("t5_clr_req", fpu_req_o, 0);
    check_val("t5_clr_gnt", apu_gnt_o, 0);
    step();
    clear_i = 1'b0;
    #1 check_val("t5_empty_req", fpu_req_o, 0);
    check_val("t5_empty_gnt", apu_gnt_o, 1);
    check_val("t5_busy_inflight", busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 check_val("t5_no_req", fpu_req_o, 0);
    end
    send_rsp(32'h0000CAFE, 5'h07);
    step();
    fpu_rvalid_i = 1'b0;
    #1 check_val("t5_rvalid", apu_rvalid_o, 1);
    check_val("t5_busy_rsp", busy_o, 1);
    step();
    #1 check_val("t5_busy_fall", busy_o, 0);

    // Response with nothing outstanding
    send_rsp(32'h00000055, 5'h1F);
    #1 check_val("t6_err_pre", rsp_err_o, 0);
    step();
    fpu_rvalid_i = 1'b0;
    #1 check_val("t6_err", rsp_err_o, 1);
    check_val("t6_outst0", dbg_outstanding_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      #1 check_val("t6_err_sticky", rsp_err_o, 1);
    end

    // Asynchronous reset mid-burst
    fpu_gnt_i = 1'b1;
    drive_push({3{32'hD1}}, 6'h3A, 15'h003A);
    step();
    drive_push({3{32'hD2}}, 6'h3B, 15'h003B);
    step();
    apu_req_i = 1'b0;
    fpu_gnt_i = 1'b0;
    #1 check_val("t6_busy_pre", busy_o, 1);
    check_val("t6_req_pre", fpu_req_o, 1);
    #2 rst_i = 1'b1;
    #1 check_val("arst_gnt", apu_gnt_o, 0);
    check_val("arst_req", fpu_req_o, 0);
    check_val("arst_ops", fpu_operands_o, 0);
    check_val("arst_op", fpu_op_o, 0);
    check_val("arst_flags", fpu_flags_o, 0);
    check_val("arst_rdata", apu_rdata_o, 0);
    check_val("arst_rflags", apu_rflags_o, 0);
    check_val("arst_busy", busy_o, 0);
    check_val("arst_err", rsp_err_o, 0);
    check_val("arst_outst", dbg_outstanding_o, 0);
    step();
    step();
    rst_i = 1'b0;
    #1 check_val("arst_gnt_back", apu_gnt_o, 1);
    check_val("arst_req_idle", fpu_req_o, 0);
    step();

    check_val("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
